tia_scan_doubler: RTL and testbench
===================================

Name: tia_scan_doubler

Overview:
- Consumes the TIA video stream: pixel-rate color plus HSYNC/HBLANK/VSYNC/VBLANK, sampled on a pixel clock-enable.
- Buffers each 160-pixel active line in a ping-pong line buffer.
- Replays each buffered line twice at the full clock rate, with regenerated sync and blank. This produces a line-doubled (~31 kHz) stream for the VGA/HDMI output stage.
- Sits between the TIA video outputs and the board video encoder.

Parameters:
- ACTIVE_W, 160: active pixels captured and replayed per line.
- LINE_LEN, 228: output clocks per replayed line.
- HB_END, 68: output hcount at which output blank deasserts.
- OHS_START, 10: output hcount at which out_hsync asserts.
- OHS_LEN, 16: out_hsync width in clocks.
- SCANLINES, 0: if 1, the second copy of each line outputs color 0 in the active region.

Ports:
- MASTERCLK  input  1  system clock, 2x TIA pixel rate.
- RES_n  input  1  asynchronous active-low reset.
- pix_ce  input  1  TIA pixel strobe; exactly one MASTERCLK in two.
- in_color  input  8  TIA COLOROUT.
- in_hblank  input  1  TIA HBLANK.
- in_vsync  input  1  TIA VSYNC.
- in_vblank  input  1  TIA VBLANK.
- out_color  output  8  doubled-line indexed color.
- out_hsync  output  1  regenerated horizontal sync.
- out_hblank  output  1  output horizontal blank.
- out_vsync  output  1  in_vsync resampled to the output line domain.
- out_vblank  output  1  in_vblank resampled to the output line domain.
- out_line2  output  1  high during the second copy of a line.

Behaviour:
- Clock and reset: one clock, MASTERCLK. Reset is asynchronous and active-low on RES_n.
- Reset values:
  - All outputs 0.
  - wr_x=0, wr_bank=0, rd_bank=1, oh=0, rep=0, valid=0, prev_hblank=1.
  - Buffer RAM contents are not reset.
- Write side (acts only when pix_ce=1):
  - prev_hblank <= in_hblank.
  - Falling edge of in_hblank (prev=1, now=0): write in_color to buf[wr_bank][0]; wr_x <= 1.
  - in_hblank=0 and 0<wr_x<ACTIVE_W: write buf[wr_bank][wr_x]; wr_x <= wr_x+1.
  - wr_x saturates at ACTIVE_W; extra active pixels are discarded, with no wrap into address 0.
  - Rising edge of in_hblank (prev=0, now=1): line_done pulse. wr_bank toggles; wr_x <= 0.
- Read side (every clock):
  - oh counts 0..LINE_LEN-1.
  - At oh=LINE_LEN-1: oh <= 0 and rep toggles.
  - line_done has priority over wrap. It forces oh <= 0, rep <= 0, rd_bank <= old wr_bank, valid <= 1.
  - Without line_done, lines keep free-running from the same rd_bank. The last completed line is repeated indefinitely, e.g. during VSYNC with HBLANK stuck high.
- Output pipeline:
  - Synchronous RAM read address = oh-HB_END when oh>=HB_END.
  - All outputs are registered and aligned one clock after the oh they describe.
  - out_hblank = (oh<HB_END).
  - out_hsync = (OHS_START <= oh < OHS_START+OHS_LEN).
  - out_line2 = rep.
  - out_color = 0 if any of: out_hblank, valid=0, or (SCANLINES=1 and rep=1). Otherwise it is the RAM data.
  - out_vsync and out_vblank load from in_vsync and in_vblank only when oh=0 and rep=0. They therefore change only at pair boundaries.
- Latency: input line N appears in both output lines starting at the line_done that ends line N, plus 1 clock.
- Arithmetic:
  - oh: 8 bits.
  - wr_x: 8 bits.
  - Read address: 8 bits; the subtraction is only valid when oh>=HB_END.
- Simultaneous events: a write to wr_bank and a read from rd_bank never collide, because the banks always differ after the first line_done.
  - Before the first line_done, reads are masked by valid=0.
- pix_ce irregularities: if pix_ce pulses closer than 2 clocks, writes still occur once per pulse and the read side is unaffected.
- Reset mid-line: everything returns to reset values immediately. Output is black until the next complete line.

Test Plan:
- Reset then idle (in_hblank=1, no edges) -> out_color=0 for 1000 clocks. out_hsync high exactly for oh 10..25 each 228-clock period; out_line2 toggles every 228 clocks.
- One line: HBLANK low for 160 pix_ce with in_color = x (0..159), then high -> next 456 clocks show two lines. In each line out_color = x at output clock HB_END+x+1 after line start; out_line2 = 0 then 1.
- SCANLINES=1, same stimulus -> first copy shows the ramp; second copy is all 0 in the active region.
- Overlong line (200 active pix_ce, colors 0..199) -> replay shows 0..159 only; buf[0] still holds 0.
- Back-to-back lines A (all 0x1E) then B (all 0x44) -> the A pair is never corrupted by B writes. The B pair follows exactly at B's line_done.
- in_vsync raised mid-pair, and RES_n pulsed low mid-line -> out_vsync changes only at the next oh=0/rep=0. After reset, all outputs are 0 and valid=0 until the next line_done.

Source files
------------

// File: rtl/tia_scan_doubler.sv
// TIA line doubler: captures each active line into a ping-pong buffer
// and replays it twice per input line with regenerated sync and blank.
module tia_scan_doubler #(
    parameter int ACTIVE_W  = 160,
    parameter int LINE_LEN  = 228,
    parameter int HB_END    = 68,
    parameter int OHS_START = 10,
    parameter int OHS_LEN   = 16,
    parameter int SCANLINES = 0
) (
    input  logic       MASTERCLK,
    input  logic       RES_n,
    input  logic       pix_ce,
    input  logic [7:0] in_color,
    input  logic       in_hblank,
    input  logic       in_vsync,
    input  logic       in_vblank,
    output logic [7:0] out_color,
    output logic       out_hsync,
    output logic       out_hblank,
    output logic       out_vsync,
    output logic       out_vblank,
    output logic       out_line2
);

    localparam logic [7:0] ACT_W   = 8'(ACTIVE_W);
    localparam logic [7:0] LAST_OH = 8'(LINE_LEN - 1);
    localparam logic [7:0] HB_E    = 8'(HB_END);
    localparam logic [7:0] HS_BEG  = 8'(OHS_START);
    localparam logic [7:0] HS_END  = 8'(OHS_START + OHS_LEN);
    localparam logic       SCAN    = (SCANLINES != 0);

    logic [7:0] wrX;
    logic       wrBank;
    logic       prevHblank;
    logic [7:0] oh;
    logic       rep;
    logic       rdBank;
    logic       valid;
    logic       colorEn;

    logic [7:0] lineBuf [0:511];
    logic [7:0] ramQ;

    logic       hbFall;
    logic       lineDone;
    logic       wrEn;
    logic [7:0] wrAddr;
    logic       rdActive;
    logic [7:0] rdAddr;

    assign hbFall   = pix_ce && prevHblank && !in_hblank;
    assign lineDone = pix_ce && !prevHblank && in_hblank;
    assign wrEn     = hbFall
                   || (pix_ce && !in_hblank && (wrX != 8'd0) && (wrX < ACT_W));
    assign wrAddr   = hbFall ? 8'd0 : wrX;

    assign rdActive = (oh >= HB_E);
    assign rdAddr   = rdActive ? (oh - HB_E) : 8'd0;

    // Bank bit on top of the pixel address; banks never coincide once valid.
    always_ff @(posedge MASTERCLK) begin
        if (wrEn) begin
            lineBuf[{wrBank, wrAddr}] <= in_color;
        end
        ramQ <= lineBuf[{rdBank, rdAddr}];
    end

    always_ff @(posedge MASTERCLK or negedge RES_n) begin
        if (!RES_n) begin
            wrX        <= 8'd0;
            wrBank     <= 1'b0;
            prevHblank <= 1'b1;
        end else if (pix_ce) begin
            prevHblank <= in_hblank;
            if (lineDone) begin
                wrBank <= ~wrBank;
                wrX    <= 8'd0;
            end else if (hbFall) begin
                wrX <= 8'd1;
            end else if (wrEn) begin
                wrX <= wrX + 8'd1;
            end
        end
    end

    always_ff @(posedge MASTERCLK or negedge RES_n) begin
        if (!RES_n) begin
            oh     <= 8'd0;
            rep    <= 1'b0;
            rdBank <= 1'b1;
            valid  <= 1'b0;
        end else if (lineDone) begin
            oh     <= 8'd0;
            rep    <= 1'b0;
            rdBank <= wrBank;
            valid  <= 1'b1;
        end else if (oh == LAST_OH) begin
            oh  <= 8'd0;
            rep <= ~rep;
        end else begin
            oh <= oh + 8'd1;
        end
    end

    // Everything here describes the oh value of the previous clock,
    // matching the one-clock latency of the buffer read.
    always_ff @(posedge MASTERCLK or negedge RES_n) begin
        if (!RES_n) begin
            out_hblank <= 1'b0;
            out_hsync  <= 1'b0;
            out_line2  <= 1'b0;
            out_vsync  <= 1'b0;
            out_vblank <= 1'b0;
            colorEn    <= 1'b0;
        end else begin
            out_hblank <= !rdActive;
            out_hsync  <= (oh >= HS_BEG) && (oh < HS_END);
            out_line2  <= rep;
            colorEn    <= rdActive && valid && !(SCAN && rep);
            if ((oh == 8'd0) && !rep) begin
                out_vsync  <= in_vsync;
                out_vblank <= in_vblank;
            end
        end
    end

    assign out_color = colorEn ? ramQ : 8'd0;

endmodule

// File: tb/tb_tia_scan_doubler.sv
// Bench for tia_scan_doubler: scoreboard of per-clock expected outputs
// for a normal and a SCANLINES=1 instance driven by the same stream.
module tb_tia_scan_doubler;

    localparam int AW  = 160;
    localparam int LL  = 228;
    localparam int HBE = 68;
    localparam int HS0 = 10;
    localparam int HSL = 16;

    logic       clk = 1'b0;
    logic       RES_n;
    logic       pix_ce;
    logic [7:0] in_color;
    logic       in_hblank;
    logic       in_vsync;
    logic       in_vblank;

    logic [7:0] color0, colorS;
    logic       hsync, hblank, vsync, vblank, line2;
    logic       hsyncS, hblankS, vsyncS, vblankS, line2S;

    tia_scan_doubler dut (
        .MASTERCLK (clk),
        .RES_n     (RES_n),
        .pix_ce    (pix_ce),
        .in_color  (in_color),
        .in_hblank (in_hblank),
        .in_vsync  (in_vsync),
        .in_vblank (in_vblank),
        .out_color (color0),
        .out_hsync (hsync),
        .out_hblank(hblank),
        .out_vsync (vsync),
        .out_vblank(vblank),
        .out_line2 (line2)
    );

    tia_scan_doubler #(.SCANLINES(1)) dutS (
        .MASTERCLK (clk),
        .RES_n     (RES_n),
        .pix_ce    (pix_ce),
        .in_color  (in_color),
        .in_hblank (in_hblank),
        .in_vsync  (in_vsync),
        .in_vblank (in_vblank),
        .out_color (colorS),
        .out_hsync (hsyncS),
        .out_hblank(hblankS),
        .out_vsync (vsyncS),
        .out_vblank(vblankS),
        .out_line2 (line2S)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        logic [7:0] cs;
        logic       l2;
        logic       hb;
        logic       hs;
        logic       vs;
        logic       vb;
    } exp_t;

    typedef struct {
        int         nAct;
        int         kind;
        logic [7:0] val;
        logic [7:0] exp0;
        logic [7:0] exp159;
    } vec_t;

    exp_t       sb[$];
    logic [7:0] lineExp [AW];
    vec_t       vecs [3];
    int         total = 0;
    int         bad = 0;

    function automatic logic [7:0] colorOf(input int kind, input int i,
                                           input logic [7:0] v);
        if (kind == 0) return 8'(i);
        if (kind == 1) return v;
        return 8'(255 - i);
    endfunction

    task automatic chk8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Expected outputs for n clocks of free-running lines from oh=0, rep=0.
    task automatic pushRun(input int n, input bit vld, input bit vs);
        for (int i = 0; i < n; i++) begin
            int   k;
            bit   r;
            exp_t e;
            k = i % LL;
            r = ((i / LL) % 2) == 1;
            e.hb = (k < HBE);
            e.hs = (k >= HS0) && (k < HS0 + HSL);
            e.l2 = r;
            e.vs = vs;
            e.vb = vs;
            e.c  = (k >= HBE && vld) ? lineExp[k - HBE] : 8'h00;
            e.cs = (k >= HBE && vld && !r) ? lineExp[k - HBE] : 8'h00;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL %s scoreboard empty at idx=%0d", tag, i);
            end else begin
                e = sb.pop_front();
                if ({color0, colorS, line2, hblank, hsync, vsync, vblank} !==
                    {e.c, e.cs, e.l2, e.hb, e.hs, e.vs, e.vb}) begin
                    bad++;
                    $display("FAIL %s idx=%0d got c=%h cs=%h l2=%b hb=%b hs=%b vs=%b vb=%b want c=%h cs=%h l2=%b hb=%b hs=%b vs=%b vb=%b",
                             tag, i, color0, colorS, line2, hblank, hsync,
                             vsync, vblank, e.c, e.cs, e.l2, e.hb, e.hs,
                             e.vs, e.vb);
                end
            end
        end
    endtask

    task automatic pix(input logic hb, input logic [7:0] c);
        in_hblank = hb;
        in_color  = c;
        pix_ce    = 1'b1;
        @(posedge clk);
        #1;
        pix_ce   = 1'b0;
        in_color = 8'hAA;
        @(posedge clk);
        #1;
    endtask

    // Returns #1 after the clock edge that samples the closing HBLANK rise.
    task automatic driveLine(input int h, input int nAct, input int kind,
                             input logic [7:0] val);
        for (int i = 0; i < h; i++) pix(1'b1, 8'hAA);
        for (int i = 0; i < nAct; i++) pix(1'b0, colorOf(kind, i, val));
        in_hblank = 1'b1;
        in_color  = 8'hAA;
        pix_ce    = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
    endtask

    task automatic chkAllZero(input string tag);
        chk8({tag, ".color"}, color0, 8'h00);
        chk8({tag, ".colorS"}, colorS, 8'h00);
        chk8({tag, ".flags"}, {3'b000, hsync, hblank, vsync, vblank, line2},
             8'h00);
        chk8({tag, ".flagsS"},
             {3'b000, hsyncS, hblankS, vsyncS, vblankS, line2S}, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nAct: 160, kind: 0, val: 8'h00, exp0: 8'h00, exp159: 8'h9F};
        vecs[1] = '{nAct: 200, kind: 0, val: 8'h00, exp0: 8'h00, exp159: 8'h9F};
        vecs[2] = '{nAct: 160, kind: 1, val: 8'h5A, exp0: 8'h5A, exp159: 8'h5A};

        RES_n     = 1'b1;
        pix_ce    = 1'b0;
        in_color  = 8'h00;
        in_hblank = 1'b1;
        in_vsync  = 1'b0;
        in_vblank = 1'b0;
        #2;
        RES_n = 1'b0;
        #10;
        chkAllZero("reset");

        @(posedge clk);
        #1;
        RES_n = 1'b1;
        for (int x = 0; x < AW; x++) lineExp[x] = 8'h00;
        pushRun(1000, 1'b0, 1'b0);
        drain(1000, "idle");

        for (int v = 0; v < 3; v++) begin
            driveLine(HBE, vecs[v].nAct, vecs[v].kind, vecs[v].val);
            for (int x = 0; x < AW; x++)
                lineExp[x] = colorOf(vecs[v].kind, x, vecs[v].val);
            lineExp[0]      = vecs[v].exp0;
            lineExp[AW - 1] = vecs[v].exp159;
            pushRun(2 * LL, 1'b1, 1'b0);
            drain(2 * LL, $sformatf("vec%0d", v));
        end

        driveLine(HBE, AW, 1, 8'h1E);
        for (int x = 0; x < AW; x++) lineExp[x] = 8'h1E;
        pushRun(2 * LL, 1'b1, 1'b0);
        fork
            drain(2 * LL, "pairA");
            begin
                @(posedge clk);
                #1;
                driveLine(HBE - 1, AW, 1, 8'h44);
            end
        join
        for (int x = 0; x < AW; x++) lineExp[x] = 8'h44;
        pushRun(2 * LL, 1'b1, 1'b0);
        drain(2 * LL, "pairB");

        pushRun(2 * LL, 1'b1, 1'b0);
        fork
            drain(2 * LL, "vsHold");
            begin
                repeat (100) @(posedge clk);
                #1;
                in_vsync  = 1'b1;
                in_vblank = 1'b1;
            end
        join
        pushRun(2 * LL, 1'b1, 1'b1);
        drain(2 * LL, "vsLoad");

        for (int i = 0; i < 10; i++) pix(1'b1, 8'hAA);
        for (int i = 0; i < 50; i++) pix(1'b0, 8'(i + 1));
        RES_n = 1'b0;
        #2;
        chkAllZero("rstMid");
        in_vsync  = 1'b0;
        in_vblank = 1'b0;
        @(posedge clk);
        #1;
        chkAllZero("rstHeld");
        RES_n = 1'b1;
        fork
            driveLine(0, AW, 2, 8'h00);
            begin
                pushRun(2 * AW + 1, 1'b0, 1'b0);
                drain(2 * AW + 1, "postRst");
            end
        join
        for (int x = 0; x < AW; x++) lineExp[x] = colorOf(2, x, 8'h00);
        pushRun(2 * LL, 1'b1, 1'b0);
        drain(2 * LL, "postRstPair");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
